// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU and the text-page video fetcher using two-phase transactions.
// Define MEM_ARBITER_VID_PRIO_EN to make video win every contention; otherwise contention is round-robin.

module mem_arbiter #(
    parameter int ADR_W        = 16,
    parameter int DAT_W        = 8,
    parameter int RST_PRIO_VID = 1
) (
    input  logic             phi,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic [DAT_W-1:0] cpu_dbo,
    output logic [DAT_W-1:0] cpu_dbi,
    output logic             cpu_ack,
    input  logic             vid_req,
    input  logic [ADR_W-1:0] vid_adr,
    output logic [DAT_W-1:0] vid_dbi,
    output logic             vid_ack,
    output logic [ADR_W-1:0] mem_adr,
    output logic             mem_we,
    output logic [DAT_W-1:0] mem_dbo,
    input  logic [DAT_W-1:0] mem_dbi
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_A,
        CPU_D,
        VID_A,
        VID_D
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   cpu_cand;
    logic   vid_cand;

`ifndef MEM_ARBITER_VID_PRIO_EN
    logic   prio_vid;
    logic   prio_vid_nxt;
`endif

    // A requester in its data phase or ack cycle is masked so a held req cannot be granted twice.
    always_comb begin
        cpu_cand  = cpu_req && (state != CPU_D) && !cpu_ack;
        vid_cand  = vid_req && (state != VID_D) && !vid_ack;
        state_nxt = state;
`ifndef MEM_ARBITER_VID_PRIO_EN
        prio_vid_nxt = prio_vid;
`endif
        case (state)
            CPU_A: state_nxt = CPU_D;
            VID_A: state_nxt = VID_D;
            default: begin
                if (cpu_cand && vid_cand) begin
`ifdef MEM_ARBITER_VID_PRIO_EN
                    state_nxt = VID_A;
`else
                    state_nxt    = prio_vid ? VID_A : CPU_A;
                    prio_vid_nxt = !prio_vid;
`endif
                end else if (cpu_cand) begin
                    state_nxt = CPU_A;
                end else if (vid_cand) begin
                    state_nxt = VID_A;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // Memory address/strobe are loaded on entry to the address phase so they are registered outputs.
    always_ff @(posedge phi) begin
        if (rst) begin
            state   <= IDLE;
            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;
            cpu_dbi <= '0;
            vid_dbi <= '0;
            mem_adr <= '0;
            mem_we  <= 1'b0;
            mem_dbo <= '0;
`ifndef MEM_ARBITER_VID_PRIO_EN
            prio_vid <= (RST_PRIO_VID != 0);
`endif
        end else begin
            state   <= state_nxt;
`ifndef MEM_ARBITER_VID_PRIO_EN
            prio_vid <= prio_vid_nxt;
`endif
            cpu_ack <= (state == CPU_D);
            vid_ack <= (state == VID_D);
            mem_we  <= 1'b0;
            if ((state == CPU_D) && !cpu_we) begin
                cpu_dbi <= mem_dbi;
            end
            if (state == VID_D) begin
                vid_dbi <= mem_dbi;
            end
            if (state_nxt == CPU_A) begin
                mem_adr <= cpu_adr;
                mem_we  <= cpu_we;
                if (cpu_we) begin
                    mem_dbo <= cpu_dbo;
                end
            end else if (state_nxt == VID_A) begin
                mem_adr <= vid_adr;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
// Honours MEM_ARBITER_VID_PRIO_EN for the expected contention winners.

module tb_mem_arbiter;

    logic        phi;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_dbo;
    logic [7:0]  cpu_dbi;
    logic        cpu_ack;
    logic        vid_req;
    logic [15:0] vid_adr;
    logic [7:0]  vid_dbi;
    logic        vid_ack;
    logic [15:0] mem_adr;
    logic        mem_we;
    logic [7:0]  mem_dbo;
    logic [7:0]  mem_dbi;

    int checks   = 0;
    int failures = 0;

    localparam bit  M_RST_PRIO_VID = 1'b1;
    localparam byte CH_V = 8'h56;
    localparam byte CH_C = 8'h43;

    mem_arbiter #(
        .ADR_W(16),
        .DAT_W(8),
        .RST_PRIO_VID(1)
    ) dut (
        .phi(phi),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_adr(cpu_adr),
        .cpu_dbo(cpu_dbo),
        .cpu_dbi(cpu_dbi),
        .cpu_ack(cpu_ack),
        .vid_req(vid_req),
        .vid_adr(vid_adr),
        .vid_dbi(vid_dbi),
        .vid_ack(vid_ack),
        .mem_adr(mem_adr),
        .mem_we(mem_we),
        .mem_dbo(mem_dbo),
        .mem_dbi(mem_dbi)
    );

    initial phi = 1'b0;
    always #5 phi = ~phi;

    // Unwritten locations read back a fixed pattern of their address.
    function automatic logic [7:0] initVal(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hC5;
    endfunction

    logic [7:0] mem [0:65535];
    bit         mem_wr [0:65535];

    always @(posedge phi) begin
        if (mem_we === 1'b1) begin
            mem[mem_adr]    <= mem_dbo;
            mem_wr[mem_adr] <= 1'b1;
        end
    end

    assign mem_dbi = mem_wr[mem_adr] ? mem[mem_adr] : initVal(mem_adr);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: who owns the port, which phase, and what each side must see.
    logic [7:0]  ref_mem [logic [15:0]];
    bit          model_on = 1'b0;
    int          m_owner;
    bit          m_data_phase;
    logic [15:0] m_adr;
    bit          m_we;
    bit          m_prio_vid;
    bit          m_cpu_in;
    bit          m_vid_in;
    bit          m_cpu_d;
    bit          m_vid_d;
    int          m_winner;
    logic        e_cpu_ack;
    logic        e_vid_ack;
    logic        e_mem_we;
    logic [15:0] e_mem_adr;
    logic [7:0]  e_cpu_dbi;
    logic [7:0]  e_vid_dbi;
    logic [7:0]  e_mem_dbo;

    function automatic logic [7:0] refRead(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : initVal(a);
    endfunction

    always @(posedge phi) begin
        if (rst) begin
            model_on     = 1'b1;
            m_owner      = 0;
            m_data_phase = 1'b0;
            m_prio_vid   = M_RST_PRIO_VID;
            e_cpu_ack    = 1'b0;
            e_vid_ack    = 1'b0;
            e_mem_we     = 1'b0;
            e_mem_adr    = '0;
            e_cpu_dbi    = '0;
            e_vid_dbi    = '0;
            e_mem_dbo    = '0;
        end else if (model_on) begin
            m_cpu_d  = (m_owner == 1) && m_data_phase;
            m_vid_d  = (m_owner == 2) && m_data_phase;
            m_cpu_in = cpu_req && !m_cpu_d && !e_cpu_ack;
            m_vid_in = vid_req && !m_vid_d && !e_vid_ack;
            if (m_cpu_d && !m_we) e_cpu_dbi = refRead(m_adr);
            if (m_vid_d) e_vid_dbi = refRead(m_adr);
            e_cpu_ack = m_cpu_d;
            e_vid_ack = m_vid_d;
            e_mem_we  = 1'b0;
            if (m_owner != 0 && !m_data_phase) begin
                m_data_phase = 1'b1;
            end else begin
                m_winner = 0;
                if (m_cpu_in && m_vid_in) begin
`ifdef MEM_ARBITER_VID_PRIO_EN
                    m_winner = 2;
`else
                    m_winner   = m_prio_vid ? 2 : 1;
                    m_prio_vid = !m_prio_vid;
`endif
                end else if (m_cpu_in) begin
                    m_winner = 1;
                end else if (m_vid_in) begin
                    m_winner = 2;
                end
                m_owner      = m_winner;
                m_data_phase = 1'b0;
                if (m_winner == 1) begin
                    m_adr     = cpu_adr;
                    m_we      = cpu_we;
                    e_mem_adr = cpu_adr;
                    if (cpu_we) begin
                        e_mem_we         = 1'b1;
                        e_mem_dbo        = cpu_dbo;
                        ref_mem[cpu_adr] = cpu_dbo;
                    end
                end else if (m_winner == 2) begin
                    m_adr     = vid_adr;
                    m_we      = 1'b0;
                    e_mem_adr = vid_adr;
                end
            end
        end
    end

    always @(negedge phi) begin
        if (model_on) begin
            checkOutput("cpu_ack", {31'd0, cpu_ack}, {31'd0, e_cpu_ack});
            checkOutput("vid_ack", {31'd0, vid_ack}, {31'd0, e_vid_ack});
            checkOutput("mem_we", {31'd0, mem_we}, {31'd0, e_mem_we});
            checkOutput("mem_adr", {16'd0, mem_adr}, {16'd0, e_mem_adr});
            checkOutput("cpu_dbi", {24'd0, cpu_dbi}, {24'd0, e_cpu_dbi});
            checkOutput("vid_dbi", {24'd0, vid_dbi}, {24'd0, e_vid_dbi});
            if (e_mem_we) checkOutput("mem_dbo", {24'd0, mem_dbo}, {24'd0, e_mem_dbo});
        end
    end

    task automatic step();
        @(posedge phi);
        #1;
    endtask

    task automatic cpuDrive(input logic req, input logic we, input logic [15:0] adr, input logic [7:0] dbo);
        cpu_req = req;
        cpu_we  = we;
        cpu_adr = adr;
        cpu_dbo = dbo;
    endtask

    task automatic vidDrive(input logic req, input logic [15:0] adr);
        vid_req = req;
        vid_adr = adr;
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        cpuDrive(1'b0, 1'b0, 16'h0000, 8'h00);
        vidDrive(1'b0, 16'h0400);
        step();
        rst = 1'b0;
    endtask

    bit cpu_busy = 1'b0;
    bit vid_busy = 1'b0;
    bit cpu_ack_prev = 1'b0;
    bit vid_ack_prev = 1'b0;

    function automatic logic [15:0] randVidAdr();
        if ($urandom_range(0, 1) == 1) return 16'h0400 + 16'($urandom_range(0, 63));
        return 16'($urandom_range(16'h0400, 16'h07F7));
    endfunction

    // Random requesters: hold until ack, then drop or re-request in the following cycle.
    task automatic applyStimulus();
        rst = ($urandom_range(0, 99) == 0);
        if (cpu_ack_prev) begin
            cpu_busy = ($urandom_range(0, 1) == 1);
            if (cpu_busy) cpuDrive(1'b1, 1'($urandom_range(0, 1)), 16'h0400 + 16'($urandom_range(0, 63)), 8'($urandom));
            else cpuDrive(1'b0, 1'b0, cpu_adr, cpu_dbo);
        end else if (!cpu_busy && $urandom_range(0, 2) == 0) begin
            cpu_busy = 1'b1;
            if ($urandom_range(0, 3) == 0) cpuDrive(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
            else cpuDrive(1'b1, 1'($urandom_range(0, 1)), 16'h0400 + 16'($urandom_range(0, 63)), 8'($urandom));
        end
        if (vid_ack_prev) begin
            vid_busy = ($urandom_range(0, 1) == 1);
            vidDrive(vid_busy, randVidAdr());
        end else if (!vid_busy && $urandom_range(0, 2) == 0) begin
            vid_busy = 1'b1;
            vidDrive(1'b1, randVidAdr());
        end
        cpu_ack_prev = cpu_ack;
        vid_ack_prev = vid_ack;
    endtask

    byte         ack_seq[$];
    logic [15:0] win_adr;
    logic [15:0] lose_adr;
    bit          vid_wins;

    initial begin
        rst = 1'b1;
        cpuDrive(1'b0, 1'b0, 16'h0000, 8'h00);
        vidDrive(1'b0, 16'h0400);
        step();
        step();
        checkOutput("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        checkOutput("rst_vid_ack", {31'd0, vid_ack}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_mem_adr", {16'd0, mem_adr}, 32'd0);
        checkOutput("rst_cpu_dbi", {24'd0, cpu_dbi}, 32'd0);
        checkOutput("rst_vid_dbi", {24'd0, vid_dbi}, 32'd0);
        checkOutput("rst_mem_dbo", {24'd0, mem_dbo}, 32'd0);

        // CPU read of $0400
        rst = 1'b0;
        cpuDrive(1'b1, 1'b0, 16'h0400, 8'h00);
        step();
        checkOutput("rd_adr_c1", {16'd0, mem_adr}, 32'h0400);
        checkOutput("rd_we_c1", {31'd0, mem_we}, 32'd0);
        step();
        checkOutput("rd_ack_c2", {31'd0, cpu_ack}, 32'd0);
        step();
        checkOutput("rd_ack_c3", {31'd0, cpu_ack}, 32'd1);
        checkOutput("rd_dbi_c3", {24'd0, cpu_dbi}, 32'hC1);
        step();
        cpuDrive(1'b0, 1'b0, 16'h0400, 8'h00);
        checkOutput("rd_ack_c4", {31'd0, cpu_ack}, 32'd0);
        step();

        // CPU write $5A to $0427
        cpuDrive(1'b1, 1'b1, 16'h0427, 8'h5A);
        step();
        checkOutput("wr_we_c1", {31'd0, mem_we}, 32'd1);
        checkOutput("wr_adr_c1", {16'd0, mem_adr}, 32'h0427);
        checkOutput("wr_dbo_c1", {24'd0, mem_dbo}, 32'h5A);
        step();
        checkOutput("wr_we_c2", {31'd0, mem_we}, 32'd0);
        step();
        checkOutput("wr_ack_c3", {31'd0, cpu_ack}, 32'd1);
        checkOutput("wr_dbi_kept", {24'd0, cpu_dbi}, 32'hC1);
        step();
        cpuDrive(1'b0, 1'b0, 16'h0427, 8'h5A);
        checkOutput("wr_ack_c4", {31'd0, cpu_ack}, 32'd0);
        checkOutput("wr_mem", {24'd0, mem[16'h0427]}, 32'h5A);
        step();

        // Simultaneous requests right after reset: video first
        resetPulse();
        cpuDrive(1'b1, 1'b0, 16'h2000, 8'h00);
        vidDrive(1'b1, 16'h0480);
        step();
        checkOutput("cont_adr_c1", {16'd0, mem_adr}, 32'h0480);
        step();
        step();
        checkOutput("cont_vack_c3", {31'd0, vid_ack}, 32'd1);
        checkOutput("cont_cack_c3", {31'd0, cpu_ack}, 32'd0);
        checkOutput("cont_adr_c3", {16'd0, mem_adr}, 32'h2000);
        step();
        vidDrive(1'b0, 16'h0480);
        step();
        checkOutput("cont_cack_c5", {31'd0, cpu_ack}, 32'd1);
        checkOutput("cont_vack_c5", {31'd0, vid_ack}, 32'd0);
        step();
        cpuDrive(1'b0, 1'b0, 16'h2000, 8'h00);
        step();

        // Both held continuously: strict alternation
        resetPulse();
        cpuDrive(1'b1, 1'b0, 16'h2100, 8'h00);
        vidDrive(1'b1, 16'h0500);
        cpu_ack_prev = 1'b0;
        vid_ack_prev = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (cpu_ack_prev) begin
                if (c <= 20) cpuDrive(1'b1, 1'b0, 16'h2100 + 16'(c), 8'h00);
                else cpuDrive(1'b0, 1'b0, cpu_adr, 8'h00);
            end
            if (vid_ack_prev) begin
                if (c <= 20) vidDrive(1'b1, 16'h0500 + 16'(c));
                else vidDrive(1'b0, vid_adr);
            end
            if (c <= 21 && vid_ack) ack_seq.push_back(CH_V);
            if (c <= 21 && cpu_ack) ack_seq.push_back(CH_C);
            cpu_ack_prev = cpu_ack;
            vid_ack_prev = vid_ack;
        end
        checkOutput("alt_count", ack_seq.size(), 32'd10);
        for (int i = 0; i < ack_seq.size(); i++) begin
            checkOutput($sformatf("alt_order%0d", i), {24'd0, ack_seq[i]}, {24'd0, (i % 2 == 0) ? CH_V : CH_C});
        end
        cpu_ack_prev = 1'b0;
        vid_ack_prev = 1'b0;
        step();

        // Reset during VID_D abandons the read
        resetPulse();
        vidDrive(1'b1, 16'h0500);
        step();
        step();
        rst = 1'b1;
        vidDrive(1'b0, 16'h0500);
        step();
        checkOutput("rstd_vack", {31'd0, vid_ack}, 32'd0);
        checkOutput("rstd_adr", {16'd0, mem_adr}, 32'd0);
        checkOutput("rstd_vdbi", {24'd0, vid_dbi}, 32'd0);
        checkOutput("rstd_cdbi", {24'd0, cpu_dbi}, 32'd0);
        checkOutput("rstd_we", {31'd0, mem_we}, 32'd0);
        rst = 1'b0;
        vidDrive(1'b1, 16'h0500);
        step();
        checkOutput("rstd_adr_c1", {16'd0, mem_adr}, 32'h0500);
        step();
        checkOutput("rstd_vack_c2", {31'd0, vid_ack}, 32'd0);
        step();
        checkOutput("rstd_vack_c3", {31'd0, vid_ack}, 32'd1);
        checkOutput("rstd_vdbi_c3", {24'd0, vid_dbi}, 32'hC0);
        step();
        vidDrive(1'b0, 16'h0500);
        step();

        // Three contentions from idle
        resetPulse();
        for (int k = 0; k < 3; k++) begin
`ifdef MEM_ARBITER_VID_PRIO_EN
            vid_wins = 1'b1;
`else
            vid_wins = (k != 1);
`endif
            cpuDrive(1'b1, 1'b0, 16'h2000 + 16'(k), 8'h00);
            vidDrive(1'b1, 16'h0480 + 16'(k));
            win_adr  = vid_wins ? 16'h0480 + 16'(k) : 16'h2000 + 16'(k);
            lose_adr = vid_wins ? 16'h2000 + 16'(k) : 16'h0480 + 16'(k);
            step();
            checkOutput($sformatf("rr%0d_win_adr", k), {16'd0, mem_adr}, {16'd0, win_adr});
            step();
            step();
            checkOutput($sformatf("rr%0d_lose_adr", k), {16'd0, mem_adr}, {16'd0, lose_adr});
            step();
            if (vid_wins) vidDrive(1'b0, vid_adr);
            else cpuDrive(1'b0, 1'b0, cpu_adr, 8'h00);
            step();
            step();
            if (vid_wins) cpuDrive(1'b0, 1'b0, cpu_adr, 8'h00);
            else vidDrive(1'b0, vid_adr);
            step();
        end

        // Randomized traffic with occasional resets
        resetPulse();
        cpu_busy = 1'b0;
        vid_busy = 1'b0;
        cpu_ack_prev = 1'b0;
        vid_ack_prev = 1'b0;
        for (int n = 0; n < 700; n++) begin
            applyStimulus();
            step();
        end
        rst = 1'b0;
        cpuDrive(1'b0, 1'b0, 16'h0000, 8'h00);
        vidDrive(1'b0, 16'h0400);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
